// File: rtl/byte_pack128_if.sv
// Byte-in / block-out stream bundle for the byte packer.
// The master side feeds bytes and drains blocks; the slave side is the packer.
interface byte_pack128_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned NB = 16,
  parameter int unsigned CW = 4
);
  logic              clr;
  logic [DW-1:0]     in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DW*NB-1:0]  out_block;
  logic              out_valid;
  logic              out_ready;
  logic [CW-1:0]     fill;

  modport master (
    output clr, in_data, in_valid, out_ready,
    input  in_ready, out_block, out_valid, fill
  );

  modport slave (
    input  clr, in_data, in_valid, out_ready,
    output in_ready, out_block, out_valid, fill
  );
endinterface

// File: rtl/byte_pack128.sv
// Packs a byte stream MSB-first into DW*NB-bit blocks with a one-block output
// holding register, so the accumulator keeps filling while downstream stalls.
module byte_pack128 #(
  parameter int unsigned DW = 8,
  parameter int unsigned NB = 16,
  parameter int unsigned CW = 4
) (
  input logic          clk,
  input logic          rst_n,
  byte_pack128_if.slave bus
);

  localparam int unsigned BW = DW * NB;
  localparam int unsigned AW = DW * (NB - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [BW-1:0] blk_q, blk_d;
  logic          vld_q, vld_d;

  logic last;
  logic in_ready_c;
  logic in_fire;
  logic out_fire;

  // Only the closing beat can stall: it needs the holding register free or draining.
  assign last       = (cnt_q == CW'(NB - 1));
  assign in_ready_c = !bus.clr && (!last || !vld_q || bus.out_ready);
  assign in_fire    = bus.in_valid && in_ready_c;
  assign out_fire   = vld_q && bus.out_ready;

  // Next-state: clear wins; a completion overrides a same-cycle drain.
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    blk_d = blk_q;
    vld_d = vld_q;
    if (bus.clr) begin
      cnt_d = '0;
      acc_d = '0;
      vld_d = 1'b0;
    end else begin
      if (out_fire) begin
        vld_d = 1'b0;
      end
      if (in_fire) begin
        if (last) begin
          blk_d = {acc_q, bus.in_data};
          vld_d = 1'b1;
          cnt_d = '0;
          acc_d = '0;
        end else begin
          acc_d = {acc_q[AW-DW-1:0], bus.in_data};
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      acc_q <= '0;
      blk_q <= '0;
      vld_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      blk_q <= blk_d;
      vld_q <= vld_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_block = blk_q;
  assign bus.out_valid = vld_q;
  assign bus.fill      = cnt_q;

endmodule
